// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states and request owner encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int MASK_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between the IFU (read-only) and the LSU (read/write),
// one access at a time, with a programmable wait before the single-cycle memory strobe.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DW-1:0]     ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [AW-1:0]     lsu_addr,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DW-1:0]     lsu_rdata,

    output logic              mem_ren,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_raddr,
    output logic [AW-1:0]     mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    owner_e              owner_q, owner_d;
    owner_e              last_grant_q, last_grant_d;
    logic                wen_q, wen_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DW-1:0]       ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0]       lsu_rdata_q, lsu_rdata_d;

    logic                grant_lsu;
    logic                grant_ifu;

    // LSU wins a tie unless it was the previous grantee.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant_q == OWN_IFU);
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        wen_d          = wen_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ifu_rdata_d    = ifu_rdata_q;
        lsu_rdata_d    = lsu_rdata_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_lsu || grant_ifu) begin
                    ifu_req_ready = grant_ifu;
                    lsu_req_ready = grant_lsu;
                    owner_d       = grant_lsu ? OWN_LSU : OWN_IFU;
                    last_grant_d  = owner_d;
                    addr_d        = grant_lsu ? lsu_addr : ifu_addr;
                    wen_d         = grant_lsu && lsu_wen;
                    wdata_d       = grant_lsu ? lsu_wdata : '0;
                    wmask_d       = grant_lsu ? lsu_wmask : '0;
                    cnt_d         = CW'(LATENCY - 1);
                    state_d       = (LATENCY == 1) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_ren = !wen_q;
                mem_wen = wen_q;
                if (owner_q == OWN_LSU) lsu_rdata_d = wen_q ? '0 : mem_rdata;
                else                    ifu_rdata_d = mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ifu_resp_valid = (owner_q == OWN_IFU);
                lsu_resp_valid = (owner_q == OWN_LSU);
                if ((owner_q == OWN_IFU && ifu_resp_ready) ||
                    (owner_q == OWN_LSU && lsu_resp_ready)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // NOTE: reset is synchronous, so the state flop still shows the old state during the
        // reset cycle; the handshake and strobe outputs are forced low here so nothing escapes.
        if (reset) begin
            ifu_req_ready  = 1'b0;
            lsu_req_ready  = 1'b0;
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
            mem_ren        = 1'b0;
            mem_wen        = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=1 (a_*) and one at LATENCY=4 (b_*).
module tb_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: LATENCY = 1 ----------------
    logic        a_reset;
    logic        a_ifu_req_valid, a_ifu_req_ready, a_ifu_resp_valid, a_ifu_resp_ready;
    logic [63:0] a_ifu_addr, a_ifu_rdata;
    logic        a_lsu_req_valid, a_lsu_req_ready, a_lsu_wen, a_lsu_resp_valid, a_lsu_resp_ready;
    logic [63:0] a_lsu_addr, a_lsu_wdata, a_lsu_rdata;
    logic [7:0]  a_lsu_wmask, a_mem_wmask;
    logic        a_mem_ren, a_mem_wen;
    logic [63:0] a_mem_raddr, a_mem_waddr, a_mem_wdata, a_mem_rdata;

    // Memory model: data = address XOR 0x8000_0013 (0x8000_0000 -> 0x13).
    assign a_mem_rdata = a_mem_raddr ^ 64'h0000_0000_8000_0013;

    mem_arbiter #(.AW(64), .DW(64), .LATENCY(1)) u_dut_a (
        .clock(clock), .reset(a_reset),
        .ifu_req_valid(a_ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(a_ifu_addr),
        .ifu_resp_valid(a_ifu_resp_valid), .ifu_resp_ready(a_ifu_resp_ready), .ifu_rdata(a_ifu_rdata),
        .lsu_req_valid(a_lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_wen(a_lsu_wen),
        .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata), .lsu_wmask(a_lsu_wmask),
        .lsu_resp_valid(a_lsu_resp_valid), .lsu_resp_ready(a_lsu_resp_ready), .lsu_rdata(a_lsu_rdata),
        .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_raddr(a_mem_raddr), .mem_waddr(a_mem_waddr),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
    );

    // ---------------- instance B: LATENCY = 4 ----------------
    logic        b_reset;
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready;
    logic [63:0] b_ifu_addr, b_ifu_rdata;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_resp_valid, b_lsu_resp_ready;
    logic [63:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
    logic [7:0]  b_lsu_wmask, b_mem_wmask;
    logic        b_mem_ren, b_mem_wen;
    logic [63:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_mem_rdata;

    assign b_mem_rdata = b_mem_raddr ^ 64'h0000_0000_8000_0013;

    mem_arbiter #(.AW(64), .DW(64), .LATENCY(4)) u_dut_b (
        .clock(clock), .reset(b_reset),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(b_ifu_resp_ready), .ifu_rdata(b_ifu_rdata),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_wen(b_lsu_wen),
        .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata), .lsu_wmask(b_lsu_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready), .lsu_rdata(b_lsu_rdata),
        .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    // Strobe counters and a ren/wen overlap detector, sampled mid-cycle.
    int a_ren_cnt = 0, a_wen_cnt = 0, b_ren_cnt = 0, b_wen_cnt = 0, overlap_cnt = 0;
    always @(negedge clock) begin
        if (a_mem_ren) a_ren_cnt++;
        if (a_mem_wen) a_wen_cnt++;
        if (b_mem_ren) b_ren_cnt++;
        if (b_mem_wen) b_wen_cnt++;
        if ((a_mem_ren && a_mem_wen) || (b_mem_ren && b_mem_wen)) overlap_cnt++;
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (a_ifu_req_ready !== 1'b0 || a_lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a: got ifu=%b lsu=%b want 0 0", a_ifu_req_ready, a_lsu_req_ready); end
            checks++; if (a_mem_ren !== 1'b0 || a_mem_wen !== 1'b0) begin errors++; $display("FAIL reset_strobe_a: got ren=%b wen=%b want 0 0", a_mem_ren, a_mem_wen); end
            checks++; if (a_ifu_resp_valid !== 1'b0 || a_lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_a: got ifu=%b lsu=%b want 0 0", a_ifu_resp_valid, a_lsu_resp_valid); end
            checks++; if (b_ifu_req_ready !== 1'b0 || b_lsu_req_ready !== 1'b0 || b_mem_ren !== 1'b0) begin errors++; $display("FAIL reset_b: got ifu_rdy=%b lsu_rdy=%b ren=%b want 0 0 0", b_ifu_req_ready, b_lsu_req_ready, b_mem_ren); end
        end
        checks++; if (a_mem_raddr !== 64'h0 || a_ifu_rdata !== 64'h0 || a_lsu_rdata !== 64'h0) begin errors++; $display("FAIL reset_regs: got raddr=%h ifu_rdata=%h lsu_rdata=%h want 0", a_mem_raddr, a_ifu_rdata, a_lsu_rdata); end
        next_cycle();
        a_reset = 1'b0; b_reset = 1'b0;
        a_ifu_req_valid = 1'b0; a_lsu_req_valid = 1'b0;
        b_ifu_req_valid = 1'b0; b_lsu_req_valid = 1'b0;
    endtask

    task automatic test_ifu_read();
        int ren0;
        next_cycle();
        ren0 = a_ren_cnt;
        a_ifu_req_valid = 1'b1; a_ifu_addr = 64'h8000_0000; a_ifu_resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (a_ifu_req_ready !== 1'b1 || a_lsu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_read_grant: got ifu=%b lsu=%b want 1 0", a_ifu_req_ready, a_lsu_req_ready); end
        checks++; if (a_mem_ren !== 1'b0) begin errors++; $display("FAIL ifu_read_early_ren: got %b want 0", a_mem_ren); end
        next_cycle();
        a_ifu_req_valid = 1'b0;
        @(negedge clock);
        checks++; if (a_mem_ren !== 1'b1 || a_mem_wen !== 1'b0) begin errors++; $display("FAIL ifu_read_strobe: got ren=%b wen=%b want 1 0", a_mem_ren, a_mem_wen); end
        checks++; if (a_mem_raddr !== 64'h8000_0000) begin errors++; $display("FAIL ifu_read_addr: got %h want 80000000", a_mem_raddr); end
        checks++; if (a_ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_read_resp_early: got %b want 0", a_ifu_resp_valid); end
        @(negedge clock);
        checks++; if (a_ifu_resp_valid !== 1'b1 || a_ifu_rdata !== 64'h13) begin errors++; $display("FAIL ifu_read_resp: got valid=%b data=%h want 1 13", a_ifu_resp_valid, a_ifu_rdata); end
        checks++; if (a_mem_ren !== 1'b0 || a_lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_read_after: got ren=%b lsu_resp=%b want 0 0", a_mem_ren, a_lsu_resp_valid); end
        @(negedge clock);
        checks++; if (a_ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_read_resp_drop: got %b want 0", a_ifu_resp_valid); end
        checks++; if (a_ren_cnt - ren0 !== 1) begin errors++; $display("FAIL ifu_read_ren_count: got %0d want 1", a_ren_cnt - ren0); end
    endtask

    task automatic test_lsu_write();
        int ren0, wen0;
        next_cycle();
        ren0 = a_ren_cnt; wen0 = a_wen_cnt;
        a_lsu_req_valid = 1'b1; a_lsu_wen = 1'b1; a_lsu_addr = 64'h8000_0100;
        a_lsu_wdata = 64'hDEAD_BEEF; a_lsu_wmask = 8'h0F; a_lsu_resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (a_lsu_req_ready !== 1'b1 || a_ifu_req_ready !== 1'b0) begin errors++; $display("FAIL lsu_write_grant: got lsu=%b ifu=%b want 1 0", a_lsu_req_ready, a_ifu_req_ready); end
        next_cycle();
        a_lsu_req_valid = 1'b0; a_lsu_wdata = 64'h0; a_lsu_wmask = 8'h00;
        @(negedge clock);
        checks++; if (a_mem_wen !== 1'b1 || a_mem_ren !== 1'b0) begin errors++; $display("FAIL lsu_write_strobe: got wen=%b ren=%b want 1 0", a_mem_wen, a_mem_ren); end
        checks++; if (a_mem_waddr !== 64'h8000_0100 || a_mem_wdata !== 64'hDEAD_BEEF || a_mem_wmask !== 8'h0F) begin errors++; $display("FAIL lsu_write_payload: got addr=%h data=%h mask=%h want 80000100 deadbeef 0f", a_mem_waddr, a_mem_wdata, a_mem_wmask); end
        @(negedge clock);
        checks++; if (a_lsu_resp_valid !== 1'b1 || a_lsu_rdata !== 64'h0) begin errors++; $display("FAIL lsu_write_resp: got valid=%b data=%h want 1 0", a_lsu_resp_valid, a_lsu_rdata); end
        @(negedge clock);
        checks++; if (a_wen_cnt - wen0 !== 1 || a_ren_cnt - ren0 !== 0) begin errors++; $display("FAIL lsu_write_counts: got wen=%0d ren=%0d want 1 0", a_wen_cnt - wen0, a_ren_cnt - ren0); end
    endtask

    task automatic test_lsu_read();
        next_cycle();
        a_lsu_req_valid = 1'b1; a_lsu_wen = 1'b0; a_lsu_addr = 64'h8000_0008;
        @(negedge clock);
        checks++; if (a_lsu_req_ready !== 1'b1) begin errors++; $display("FAIL lsu_read_grant: got %b want 1", a_lsu_req_ready); end
        next_cycle();
        a_lsu_req_valid = 1'b0;
        @(negedge clock);
        checks++; if (a_mem_ren !== 1'b1 || a_mem_wen !== 1'b0) begin errors++; $display("FAIL lsu_read_strobe: got ren=%b wen=%b want 1 0", a_mem_ren, a_mem_wen); end
        @(negedge clock);
        checks++; if (a_lsu_resp_valid !== 1'b1 || a_lsu_rdata !== 64'h1B) begin errors++; $display("FAIL lsu_read_resp: got valid=%b data=%h want 1 1b", a_lsu_resp_valid, a_lsu_rdata); end
        checks++; if (a_ifu_resp_valid !== 1'b0 || a_ifu_rdata !== 64'h13) begin errors++; $display("FAIL lsu_read_ifu_side: got valid=%b data=%h want 0 13", a_ifu_resp_valid, a_ifu_rdata); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_grant [4];
        logic [1:0] got;
        exp_grant = '{2'b10, 2'b01, 2'b10, 2'b01};
        next_cycle();
        a_reset = 1'b1;
        next_cycle();
        next_cycle();
        a_reset = 1'b0;
        a_ifu_req_valid = 1'b1; a_ifu_addr = 64'h8000_0000;
        a_lsu_req_valid = 1'b1; a_lsu_wen = 1'b0; a_lsu_addr = 64'h8000_0200;
        a_ifu_resp_ready = 1'b1; a_lsu_resp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 2'b00;
            for (int w = 0; w < 10; w++) begin
                @(negedge clock);
                if (a_ifu_req_ready || a_lsu_req_ready) begin
                    got = {a_lsu_req_ready, a_ifu_req_ready};
                    break;
                end
            end
            checks++; if (got !== exp_grant[g]) begin errors++; $display("FAIL rr_grant_%0d: got {lsu,ifu}=%b want %b", g, got, exp_grant[g]); end
        end
        next_cycle();
        a_ifu_req_valid = 1'b0; a_lsu_req_valid = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (a_lsu_rdata !== 64'h213 || a_ifu_rdata !== 64'h13) begin errors++; $display("FAIL rr_data: got lsu=%h ifu=%h want 213 13", a_lsu_rdata, a_ifu_rdata); end
    endtask

    task automatic test_latency();
        int ren0;
        next_cycle();
        ren0 = b_ren_cnt;
        b_ifu_req_valid = 1'b1; b_ifu_addr = 64'h8000_0040; b_ifu_resp_ready = 1'b0;
        @(negedge clock);
        checks++; if (b_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL lat_grant: got %b want 1", b_ifu_req_ready); end
        next_cycle();
        b_ifu_req_valid = 1'b0;
        b_lsu_req_valid = 1'b1; b_lsu_wen = 1'b0; b_lsu_addr = 64'h8000_0000; b_lsu_resp_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            checks++; if (b_mem_ren !== 1'b0 || b_lsu_req_ready !== 1'b0) begin errors++; $display("FAIL lat_wait_%0d: got ren=%b lsu_rdy=%b want 0 0", k, b_mem_ren, b_lsu_req_ready); end
        end
        @(negedge clock);
        checks++; if (b_mem_ren !== 1'b1 || b_mem_raddr !== 64'h8000_0040) begin errors++; $display("FAIL lat_strobe: got ren=%b addr=%h want 1 80000040", b_mem_ren, b_mem_raddr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++; if (b_ifu_resp_valid !== 1'b1 || b_ifu_rdata !== 64'h53 || b_lsu_req_ready !== 1'b0 || b_mem_ren !== 1'b0) begin errors++; $display("FAIL lat_hold_%0d: got valid=%b data=%h lsu_rdy=%b ren=%b want 1 53 0 0", k, b_ifu_resp_valid, b_ifu_rdata, b_lsu_req_ready, b_mem_ren); end
        end
        next_cycle();
        b_ifu_resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (b_ifu_resp_valid !== 1'b1 || b_lsu_req_ready !== 1'b0) begin errors++; $display("FAIL lat_handshake: got valid=%b lsu_rdy=%b want 1 0", b_ifu_resp_valid, b_lsu_req_ready); end
        @(negedge clock);
        checks++; if (b_ifu_resp_valid !== 1'b0 || b_lsu_req_ready !== 1'b1) begin errors++; $display("FAIL lat_next_grant: got valid=%b lsu_rdy=%b want 0 1", b_ifu_resp_valid, b_lsu_req_ready); end
        checks++; if (b_ren_cnt - ren0 !== 1) begin errors++; $display("FAIL lat_ren_count: got %0d want 1", b_ren_cnt - ren0); end
        next_cycle();
        b_lsu_req_valid = 1'b0;
        repeat (7) @(negedge clock);
        checks++; if (b_lsu_rdata !== 64'h13 || b_ren_cnt - ren0 !== 2) begin errors++; $display("FAIL lat_lsu_done: got data=%h ren=%0d want 13 2", b_lsu_rdata, b_ren_cnt - ren0); end
    endtask

    task automatic test_reset_in_wait();
        int ren0;
        next_cycle();
        ren0 = b_ren_cnt;
        b_ifu_req_valid = 1'b1; b_ifu_addr = 64'h8000_0080; b_ifu_resp_ready = 1'b1;
        @(negedge clock);
        checks++; if (b_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_grant: got %b want 1", b_ifu_req_ready); end
        next_cycle();
        b_ifu_req_valid = 1'b0;
        b_reset = 1'b1;
        @(negedge clock);
        checks++; if (b_mem_ren !== 1'b0) begin errors++; $display("FAIL rstw_ren_wait: got %b want 0", b_mem_ren); end
        next_cycle();
        b_reset = 1'b0;
        repeat (6) @(negedge clock);
        checks++; if (b_ren_cnt - ren0 !== 0 || b_ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_abandon: got ren=%0d resp=%b want 0 0", b_ren_cnt - ren0, b_ifu_resp_valid); end
        next_cycle();
        b_ifu_req_valid = 1'b1; b_ifu_addr = 64'h8000_00A0;
        @(negedge clock);
        checks++; if (b_ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_idle: got %b want 1", b_ifu_req_ready); end
        next_cycle();
        b_ifu_req_valid = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (b_ifu_resp_valid !== 1'b1 || b_ifu_rdata !== 64'hB3) begin errors++; $display("FAIL rstw_recover: got valid=%b data=%h want 1 b3", b_ifu_resp_valid, b_ifu_rdata); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_ifu_req_valid = 1'b1; a_ifu_addr = 64'h8000_0000; a_ifu_resp_ready = 1'b1;
        a_lsu_req_valid = 1'b1; a_lsu_wen = 1'b0; a_lsu_addr = 64'h8000_0100;
        a_lsu_wdata = 64'h0; a_lsu_wmask = 8'h00; a_lsu_resp_ready = 1'b1;
        b_ifu_req_valid = 1'b1; b_ifu_addr = 64'h8000_0000; b_ifu_resp_ready = 1'b1;
        b_lsu_req_valid = 1'b1; b_lsu_wen = 1'b0; b_lsu_addr = 64'h8000_0100;
        b_lsu_wdata = 64'h0; b_lsu_wmask = 8'h00; b_lsu_resp_ready = 1'b1;

        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_lsu_read();
        test_back_to_back();
        test_latency();
        test_reset_in_wait();

        checks++; if (overlap_cnt !== 0 || b_wen_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got overlap=%0d b_wen=%0d want 0 0", overlap_cnt, b_wen_cnt); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
